pc_enable: RTL and testbench

PC_ENABLE -- requirements
Module: pc_enable

---
 rtl/pc_enable_pkg.sv | 13 +
 rtl/pc_en_logic.sv | 12 +
 rtl/pc_enable.sv | 62 ++++++
 tb/tb_pc_enable.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pc_enable_pkg.sv
// Shared MIPS definitions for next-PC selection and the default reset vector.
package pc_enable_pkg;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_RSVD   = 2'b11
  } pc_src_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : pc_enable_pkg

// File: rtl/pc_en_logic.sv
// PC load enable: unconditional write or a taken beq/bne.
module pc_en_logic (
  input  logic PCWrite,
  input  logic Branch,
  input  logic BranchNe,
  input  logic Zero,
  output logic PCEn
);

  assign PCEn = PCWrite | (Branch & Zero) | (BranchNe & ~Zero);

endmodule : pc_en_logic

// File: rtl/pc_enable.sv
// Program counter register with next-PC source mux and branch/write enable.
module pc_enable
  import pc_enable_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic             BranchNe,
  input  logic             Zero,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] Instr,
  output logic             PCEn,
  output logic [WIDTH-1:0] PCNext,
  output logic [WIDTH-1:0] PC,
  output logic             PCMisaligned
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             unused_instr_hi;

  // Opcode bits above the jump index are not needed here.
  assign unused_instr_hi = ^Instr[WIDTH-1:26];

  pc_en_logic u_pc_en_logic (
    .PCWrite  (PCWrite),
    .Branch   (Branch),
    .BranchNe (BranchNe),
    .Zero     (Zero),
    .PCEn     (PCEn)
  );

  always_comb begin
    pc_d = ALUResult;
    unique case (pc_src_e'(PCSrc))
      PC_SRC_ALU:    pc_d = ALUResult;
      PC_SRC_ALUOUT: pc_d = ALUOut;
      PC_SRC_JUMP:   pc_d = {pc_q[WIDTH-1:28], Instr[25:0], 2'b00};
      PC_SRC_RSVD:   pc_d = ALUResult;
      default:       pc_d = ALUResult;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (PCEn) begin
      pc_q <= pc_d;
    end
  end

  assign PCNext       = pc_d;
  assign PC           = pc_q;
  assign PCMisaligned = |pc_q[1:0];

endmodule : pc_enable

// File: tb/tb_pc_enable.sv
// Directed bench for pc_enable: enable truth table, mux selects, register and async reset.
module tb_pc_enable;

  logic        clk;
  logic        rst_n;
  logic        PCWrite;
  logic        Branch;
  logic        BranchNe;
  logic        Zero;
  logic [1:0]  PCSrc;
  logic [31:0] ALUResult;
  logic [31:0] ALUOut;
  logic [31:0] Instr;
  logic        PCEn;
  logic [31:0] PCNext;
  logic [31:0] PC;
  logic        PCMisaligned;

  int unsigned checks;
  int unsigned errors;

  pc_enable #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCWrite      (PCWrite),
    .Branch       (Branch),
    .BranchNe     (BranchNe),
    .Zero         (Zero),
    .PCSrc        (PCSrc),
    .ALUResult    (ALUResult),
    .ALUOut       (ALUOut),
    .Instr        (Instr),
    .PCEn         (PCEn),
    .PCNext       (PCNext),
    .PC           (PC),
    .PCMisaligned (PCMisaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic w, input logic b, input logic bn, input logic z);
    PCWrite  = w;
    Branch   = b;
    BranchNe = bn;
    Zero     = z;
  endtask

  typedef struct {
    logic w;
    logic b;
    logic bn;
    logic z;
    logic en;
  } en_vec_t;

  en_vec_t en_tab[$];

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    set_en(0, 0, 0, 0);
    PCSrc = 2'b00;
    ALUResult = '0;
    ALUOut = '0;
    Instr = '0;
    #1;
    chk("reset_pc", PC, 32'h0);
    chk("reset_misaligned", 32'(PCMisaligned), 32'h0);

    en_tab.push_back('{0, 0, 0, 0, 0});
    en_tab.push_back('{1, 0, 0, 0, 1});
    en_tab.push_back('{0, 1, 0, 0, 0});
    en_tab.push_back('{0, 1, 0, 1, 1});
    en_tab.push_back('{1, 1, 0, 1, 1});
    en_tab.push_back('{0, 0, 1, 0, 1});
    en_tab.push_back('{0, 0, 1, 1, 0});
    en_tab.push_back('{0, 1, 1, 0, 1});
    en_tab.push_back('{0, 1, 1, 1, 1});
    foreach (en_tab[i]) begin
      set_en(en_tab[i].w, en_tab[i].b, en_tab[i].bn, en_tab[i].z);
      #10;
      chk($sformatf("pcen_%0d", i), 32'(PCEn), 32'(en_tab[i].en));
    end

    // Reset held: enabled write must not load.
    set_en(1, 0, 0, 0);
    ALUResult = 32'h4;
    tick();
    chk("reset_hold", PC, 32'h0);
    chk("reset_pcnext", PCNext, 32'h4);

    rst_n = 1'b1;
    tick();
    chk("load_4", PC, 32'h4);
    set_en(0, 0, 0, 0);
    ALUResult = 32'h8;
    repeat (3) tick();
    chk("hold_4", PC, 32'h4);

    PCSrc = 2'b01;
    ALUOut = 32'h4000_0000;
    #1;
    chk("mux_aluout", PCNext, 32'h4000_0000);
    PCSrc = 2'b11;
    #1;
    chk("mux_rsvd", PCNext, 32'h8);

    PCSrc = 2'b01;
    set_en(0, 1, 0, 0);
    tick();
    chk("beq_not_taken", PC, 32'h4);
    set_en(0, 1, 0, 1);
    tick();
    chk("beq_taken", PC, 32'h4000_0000);

    Instr = 32'h0800_0010;
    PCSrc = 2'b10;
    set_en(1, 0, 0, 0);
    #1;
    chk("jump_pcnext", PCNext, 32'h4000_0040);
    tick();
    chk("jump_pc", PC, 32'h4000_0040);

    PCSrc = 2'b00;
    ALUResult = 32'h40;
    tick();
    chk("load_40", PC, 32'h40);

    // Async reset between edges.
    ALUResult = 32'h44;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", PC, 32'h0);
    set_en(0, 0, 1, 0);
    ALUResult = 32'h6;
    #1;
    chk("reset_pcen_comb", 32'(PCEn), 32'h1);
    tick();
    chk("reset_discard", PC, 32'h0);

    rst_n = 1'b1;
    set_en(0, 0, 0, 0);
    tick();
    chk("no_load_disabled", PC, 32'h0);
    set_en(1, 0, 0, 0);
    tick();
    chk("misaligned_pc", PC, 32'h6);
    chk("misaligned_flag", 32'(PCMisaligned), 32'h1);

    ALUResult = 32'hFFFF_FFFF;
    tick();
    chk("wrap_max", PC, 32'hFFFF_FFFF);
    ALUResult = 32'h0;
    tick();
    chk("wrap_zero", PC, 32'h0);
    chk("aligned_flag", 32'(PCMisaligned), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_enable
